neuron_mac_seq: RTL

- Sequential, parametrised successor to the two-input combinational linear neuron.
- Computes y = sat(sum over i of x[i]*w[i] + b) for N signed fixed-point inputs, using one shared multiplier over N cycles.
- Valid/ready handshakes on both input and output, so the block can be chained into layer pipelines.
- Sits between the input/weight source and the activation/next-layer logic.

---
 rtl/neuron_mac_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/neuron_mac_seq.sv
// Sequential N-input fixed-point neuron: one shared multiplier, valid/ready on both sides.
// Optional ReLU on the output when NEURON_RELU_EN is defined.
module neuron_mac_seq #(
  parameter int N    = 4,
  parameter int B    = 16,
  parameter int FRAC = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*B-1:0] x,
  input  logic [N*B-1:0] w,
  input  logic [B-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [B-1:0]   y,
  output logic           busy
);

  localparam int ACC_W = 2*B + $clog2(N) + 1;
  localparam int IDX_W = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_BIAS = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-B+1){1'b0}}, {(B-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-B+1){1'b1}}, {(B-1){1'b0}}};
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(N-1);

  logic [1:0]              state;
  logic [N*B-1:0]          xr;
  logic [N*B-1:0]          wr;
  logic [B-1:0]            br;
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        idx;

  logic [B-1:0]            xs;
  logic [B-1:0]            ws;
  logic [2*B-1:0]          prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_b;
  logic signed [ACC_W-1:0] r;
  logic [B-1:0]            y_sat;
  logic [B-1:0]            y_next;

  always_comb begin
    xs = xr[idx*B +: B];
    ws = wr[idx*B +: B];
    // Operands sign-extended to 2B so the low 2B product bits are the exact signed product
    prod     = {{B{xs[B-1]}}, xs} * {{B{ws[B-1]}}, ws};
    prod_ext = {{(ACC_W-2*B){prod[2*B-1]}}, prod};
    bias_ext = {{(ACC_W-B-FRAC){br[B-1]}}, br, {FRAC{1'b0}}};
    acc_b    = acc + bias_ext;
    r        = acc_b >>> FRAC;
    if (r > Y_MAX) begin
      y_sat = {1'b0, {(B-1){1'b1}}};
    end else if (r < Y_MIN) begin
      y_sat = {1'b1, {(B-1){1'b0}}};
    end else begin
      y_sat = r[B-1:0];
    end
`ifdef NEURON_RELU_EN
    y_next = y_sat[B-1] ? '0 : y_sat;
`else
    y_next = y_sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      xr    <= '0;
      wr    <= '0;
      br    <= '0;
      acc   <= '0;
      idx   <= '0;
      y     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            xr    <= x;
            wr    <= w;
            br    <= b;
            acc   <= '0;
            idx   <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= S_BIAS;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_BIAS: begin
          acc   <= acc_b;
          y     <= y_next;
          state <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule
